// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: source-side request bus and CDB broadcast bus of the CDB arbiter.
//   master : the arbiter. It samples per-source valid/payload and rob_ready_i,
//            and drives ready_o plus the cdb_* broadcast.
//   slave  : the environment, meaning the reservation stations and the ROB.
// Per-source fields are packed, with source i at [i*W +: W].
interface cdb_arbiter_if #(
  parameter int N_EU        = 4,
  parameter int XLEN        = 64,
  parameter int ROB_IDX_LEN = 6,
  parameter int EXCEPT_LEN  = 4
);
  logic [N_EU-1:0]             valid_i;
  logic [N_EU-1:0]             ready_o;
  logic [N_EU*ROB_IDX_LEN-1:0] idx_i;
  logic [N_EU*XLEN-1:0]        data_i;
  logic [N_EU-1:0]             except_raised_i;
  logic [N_EU*EXCEPT_LEN-1:0]  except_code_i;
  logic                        rob_ready_i;
  logic                        cdb_valid_o;
  logic [ROB_IDX_LEN-1:0]      cdb_idx_o;
  logic [XLEN-1:0]             cdb_data_o;
  logic                        cdb_except_raised_o;
  logic [EXCEPT_LEN-1:0]       cdb_except_o;

  modport master (
    input  valid_i, idx_i, data_i, except_raised_i, except_code_i, rob_ready_i,
    output ready_o, cdb_valid_o, cdb_idx_o, cdb_data_o, cdb_except_raised_o, cdb_except_o
  );

  modport slave (
    output valid_i, idx_i, data_i, except_raised_i, except_code_i, rob_ready_i,
    input  ready_o, cdb_valid_o, cdb_idx_o, cdb_data_o, cdb_except_raised_o, cdb_except_o
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter plus output register for the common data bus.
// Each cycle it grants at most one reservation-station result, registers it,
// and broadcasts it to the ROB and to all stations one cycle later.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   flush_i : synchronous flush; drops the held result and blocks grants that cycle
//   bus     : cdb_arbiter_if.master, carrying the source valid/ready/payload and the cdb_* broadcast
module cdb_arbiter #(
  parameter int N_EU        = 4,
  parameter int XLEN        = 64,
  parameter int ROB_IDX_LEN = 6,
  parameter int EXCEPT_LEN  = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  cdb_arbiter_if.master  bus
);
  localparam int PW = (N_EU > 1) ? $clog2(N_EU) : 1;

  logic                   valid_q, valid_d;
  logic [ROB_IDX_LEN-1:0] idx_q, idx_d;
  logic [XLEN-1:0]        data_q, data_d;
  logic                   exr_q, exr_d;
  logic [EXCEPT_LEN-1:0]  exc_q, exc_d;
  logic [PW-1:0]          prio_q, prio_d;

  logic          accept, found, xfer;
  logic [PW-1:0] gnt;
  int            j;

  // Rotating scan that starts at prio_q. The first valid source wins.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    j     = 0;
    for (int k = 0; k < N_EU; k++) begin
      j = int'(prio_q) + k;
      if (j >= N_EU) j = j - N_EU;
      if (!found && bus.valid_i[j]) begin
        found = 1'b1;
        gnt   = PW'(j);
      end
    end
  end

  // The register can take a new result when it is empty or draining this cycle.
  assign accept = !valid_q || bus.rob_ready_i;
  assign xfer   = !rst_i && !flush_i && accept && found;

  always_comb begin
    bus.ready_o = '0;
    if (xfer) bus.ready_o[gnt] = 1'b1;
  end

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    data_d  = data_q;
    exr_d   = exr_q;
    exc_d   = exc_q;
    prio_d  = prio_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (xfer) begin
      // A load overwrites any draining entry, so no bubble is inserted.
      valid_d = 1'b1;
      idx_d   = bus.idx_i[gnt*ROB_IDX_LEN +: ROB_IDX_LEN];
      data_d  = bus.data_i[gnt*XLEN +: XLEN];
      exr_d   = bus.except_raised_i[gnt];
      exc_d   = bus.except_code_i[gnt*EXCEPT_LEN +: EXCEPT_LEN];
      prio_d  = (gnt == PW'(N_EU-1)) ? '0 : gnt + 1'b1;
    end else if (bus.rob_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      exr_q   <= 1'b0;
      exc_q   <= '0;
      prio_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      exr_q   <= exr_d;
      exc_q   <= exc_d;
      prio_q  <= prio_d;
    end
  end

  assign bus.cdb_valid_o         = valid_q;
  assign bus.cdb_idx_o           = idx_q;
  assign bus.cdb_data_o          = data_q;
  assign bus.cdb_except_raised_o = exr_q;
  assign bus.cdb_except_o        = exc_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter (N_EU=4, XLEN=64, ROB_IDX_LEN=6, EXCEPT_LEN=4).
// Inputs change on the falling edge. ready_o is sampled 2 ns later. The
// registered outputs are sampled on the falling edge that follows the
// loading rising edge.
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst, flush;
  int   vectors = 0;
  int   miscompares = 0;

  cdb_arbiter_if #(.N_EU(4), .XLEN(64), .ROB_IDX_LEN(6), .EXCEPT_LEN(4)) bus ();

  cdb_arbiter #(.N_EU(4), .XLEN(64), .ROB_IDX_LEN(6), .EXCEPT_LEN(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  // Source i carries idx 10+i, data 0x100+i, and no exception by default.
  task automatic set_payloads();
    for (int i = 0; i < 4; i++) begin
      bus.idx_i[i*6 +: 6]        = 6'(10 + i);
      bus.data_i[i*64 +: 64]     = 64'h100 + 64'(i);
      bus.except_raised_i[i]     = 1'b0;
      bus.except_code_i[i*4 +: 4] = 4'h0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; bus.rob_ready_i = 1'b1; bus.valid_i = 4'b1111;
    set_payloads();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #2;
      vectors++;
      if (bus.ready_o !== 4'b0000 || bus.cdb_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold cyc%0d ready=%b cdb_valid=%b exp ready=0000 cdb_valid=0", c, bus.ready_o, bus.cdb_valid_o);
      end
    end
    @(negedge clk); rst = 1'b0;
    vectors++;
    if (bus.cdb_valid_o !== 1'b0 || bus.cdb_data_o !== 64'h0 || bus.cdb_idx_o !== 6'h0) begin
      miscompares++;
      $display("FAIL reset_state valid=%b data=%h idx=%h exp 0/0/0", bus.cdb_valid_o, bus.cdb_data_o, bus.cdb_idx_o);
    end
    #2;
    vectors++;
    if (bus.ready_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_release ready=%b exp=0001", bus.ready_o);
    end
  endtask

  // Source 0 was granted on reset release, so the pointer now sits at 1.
  task automatic test_single();
    @(negedge clk);
    bus.valid_i = 4'b0100; bus.idx_i[12 +: 6] = 6'd5; bus.data_i[128 +: 64] = 64'hDEAD;
    #2;
    vectors++;
    if (bus.ready_o !== 4'b0100) begin
      miscompares++;
      $display("FAIL single_ready ready=%b exp=0100", bus.ready_o);
    end
    @(negedge clk);
    set_payloads(); bus.valid_i = 4'b1111;
    vectors++;
    if (bus.cdb_valid_o !== 1'b1 || bus.cdb_idx_o !== 6'd5 || bus.cdb_data_o !== 64'hDEAD || bus.cdb_except_raised_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_out valid=%b idx=%0d data=%h exr=%b exp 1/5/dead/0", bus.cdb_valid_o, bus.cdb_idx_o, bus.cdb_data_o, bus.cdb_except_raised_o);
    end
    // With the pointer at 3 and every source requesting, source 3 must win.
    #2;
    vectors++;
    if (bus.ready_o !== 4'b1000) begin
      miscompares++;
      $display("FAIL single_prio3 ready=%b exp=1000", bus.ready_o);
    end
  endtask

  // All sources keep requesting. Source 3 was granted in the cycle above.
  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #2;
      vectors++;
      if (bus.ready_o !== exp_g[c]) begin
        miscompares++;
        $display("FAIL rr_grant cyc%0d ready=%b exp=%b", c, bus.ready_o, exp_g[c]);
      end
      // The broadcast holds the previous cycle's winner, which is 3 before the first grant.
      vectors++;
      if (bus.cdb_valid_o !== 1'b1 || bus.cdb_data_o !== 64'h100 + 64'((c + 3) % 4)) begin
        miscompares++;
        $display("FAIL rr_cdb cyc%0d valid=%b data=%h exp 1/%h", c, bus.cdb_valid_o, bus.cdb_data_o, 64'h100 + 64'((c + 3) % 4));
      end
    end
  endtask

  // The pointer is at 1 after the final grant to source 0.
  task automatic test_backpressure();
    @(negedge clk); bus.valid_i = 4'b0010; #2;
    vectors++;
    if (bus.ready_o !== 4'b0010) begin
      miscompares++;
      $display("FAIL bp_first ready=%b exp=0010", bus.ready_o);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); bus.valid_i = 4'b1010; bus.rob_ready_i = 1'b0; #2;
      vectors++;
      if (bus.ready_o !== 4'b0000 || bus.cdb_valid_o !== 1'b1 || bus.cdb_data_o !== 64'h101 || bus.cdb_idx_o !== 6'd11) begin
        miscompares++;
        $display("FAIL bp_hold cyc%0d ready=%b valid=%b data=%h idx=%0d exp 0000/1/101/11", c, bus.ready_o, bus.cdb_valid_o, bus.cdb_data_o, bus.cdb_idx_o);
      end
    end
    @(negedge clk); bus.rob_ready_i = 1'b1; #2;
    vectors++;
    if (bus.ready_o !== 4'b1000) begin
      miscompares++;
      $display("FAIL bp_release ready=%b exp=1000", bus.ready_o);
    end
    @(negedge clk); bus.valid_i = 4'b0000;
    vectors++;
    if (bus.cdb_valid_o !== 1'b1 || bus.cdb_data_o !== 64'h103) begin
      miscompares++;
      $display("FAIL bp_after valid=%b data=%h exp 1/103", bus.cdb_valid_o, bus.cdb_data_o);
    end
  endtask

  // The output holds source 3 and the pointer is at 0.
  task automatic test_flush();
    bus.valid_i = 4'b0001; flush = 1'b1; #2;
    vectors++;
    if (bus.ready_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL flush_ready ready=%b exp=0000", bus.ready_o);
    end
    @(negedge clk); flush = 1'b0;
    vectors++;
    if (bus.cdb_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_drop cdb_valid=%b exp=0", bus.cdb_valid_o);
    end
    #2;
    vectors++;
    if (bus.ready_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL flush_regrant ready=%b exp=0001", bus.ready_o);
    end
    @(negedge clk); bus.valid_i = 4'b0000;
    vectors++;
    if (bus.cdb_valid_o !== 1'b1 || bus.cdb_data_o !== 64'h100) begin
      miscompares++;
      $display("FAIL flush_load valid=%b data=%h exp 1/100", bus.cdb_valid_o, bus.cdb_data_o);
    end
  endtask

  // The pointer is at 1. Only source 3 requests, and it carries an exception.
  task automatic test_except_wrap();
    bus.valid_i = 4'b1000; bus.except_raised_i[3] = 1'b1; bus.except_code_i[12 +: 4] = 4'hB; #2;
    vectors++;
    if (bus.ready_o !== 4'b1000) begin
      miscompares++;
      $display("FAIL exc_ready ready=%b exp=1000", bus.ready_o);
    end
    @(negedge clk);
    set_payloads(); bus.valid_i = 4'b1111;
    vectors++;
    if (bus.cdb_valid_o !== 1'b1 || bus.cdb_except_raised_o !== 1'b1 || bus.cdb_except_o !== 4'hB || bus.cdb_idx_o !== 6'd13) begin
      miscompares++;
      $display("FAIL exc_out valid=%b exr=%b code=%h idx=%0d exp 1/1/b/13", bus.cdb_valid_o, bus.cdb_except_raised_o, bus.cdb_except_o, bus.cdb_idx_o);
    end
    #2;
    vectors++;
    if (bus.ready_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL exc_wrap ready=%b exp=0001", bus.ready_o);
    end
  endtask

  // With no requesters and rob_ready_i high, the register drains.
  task automatic test_drain();
    @(negedge clk); bus.valid_i = 4'b0000; #2;
    vectors++;
    if (bus.ready_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL drain_ready ready=%b exp=0000", bus.ready_o);
    end
    @(negedge clk);
    vectors++;
    if (bus.cdb_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_valid cdb_valid=%b exp=0", bus.cdb_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_except_wrap();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
